vpu_issue_stage_sb: RTL

- Next-generation VPU issue stage: parametrised in-order instruction queue plus per-register scoreboard and multi-port dispatch.
- Sits between the VPU decoder and the execute stage.
- Blocks RAW/WAW hazards on vector registers and routes each uOP to its own FU port.
- Serialises VCFG (zicsr, vset[i]vl[i]) behind all older vector work; VCFG ops still bypass the queue.

---
 rtl/vpu_issue_stage_sb_pkg.sv | 37 +++
 rtl/vpu_issue_queue.sv | 55 +++++
 rtl/vpu_issue_stage_sb.sv | 103 ++++++++++
 3 files changed

// File: rtl/vpu_issue_stage_sb_pkg.sv
// Shared VPU types: uOP format, functional-unit encoding and FU-to-port routing.
package vpu_issue_stage_sb_pkg;

    localparam int VPU_NUM_VREG = 32;
    localparam int VREG_W       = $clog2(VPU_NUM_VREG);
    localparam int PORT_W       = 2;

    typedef enum logic [1:0] {
        FU_VCFG = 2'd0,
        FU_ALU  = 2'd1,
        FU_MUL  = 2'd2,
        FU_LSU  = 2'd3
    } fu_e;

    typedef struct packed {
        logic [7:0]        tag;
        fu_e               fu;
        logic [VREG_W-1:0] vd;
        logic [VREG_W-1:0] vs1;
        logic [VREG_W-1:0] vs2;
        logic              use_vs1;
        logic              use_vs2;
        logic              use_vd_src;
        logic              wr_vd;
    } VPU_uOP_t;

    // Dispatch port owned by each non-VCFG FU; VCFG never reaches a dispatch port.
    function automatic logic [PORT_W-1:0] fu2port(input fu_e fu);
        case (fu)
            FU_ALU:  return 2'd0;
            FU_MUL:  return 2'd1;
            FU_LSU:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vpu_issue_queue.sv
// In-order circular uOP queue with push, pop and flush; head is always visible.
module vpu_issue_queue
    import vpu_issue_stage_sb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  VPU_uOP_t         push_data,
    input  logic             pop,
    input  logic             flush,
    output VPU_uOP_t         head,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    VPU_uOP_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
    // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload write; validity is tracked entirely by pointers and count.
    // NOTE: the payload array is deliberately not reset, so it can map onto plain storage.
    always_ff @(posedge clk_i) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];
    assign full = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/vpu_issue_stage_sb.sv
// VPU issue stage: in-order queue, vector-register scoreboard, per-FU dispatch
// and VCFG serialisation behind all older vector work.
module vpu_issue_stage_sb
    import vpu_issue_stage_sb_pkg::*;
#(
    parameter  int DEPTH    = 4,
    parameter  int NUM_FU   = 3,
    parameter  int NUM_WB   = 2,
    parameter  int NUM_VREG = VPU_NUM_VREG,
    localparam int CNT_W    = $clog2(DEPTH + 1),
    localparam int VD_W     = $clog2(NUM_VREG)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           decode_entry_valid_i,
    input  VPU_uOP_t                       decode_entry_i,
    output logic                           decode_ack_o,
    output logic                           VCFG_valid_o,
    output VPU_uOP_t                       VCFG_entry_o,
    output logic [NUM_FU-1:0]              dispatch_valid_o,
    output VPU_uOP_t                       dispatch_entry_o,
    input  logic [NUM_FU-1:0]              dispatch_ready_i,
    input  logic [NUM_WB-1:0]              wb_valid_i,
    input  logic [NUM_WB-1:0][VD_W-1:0]    wb_vd_i,
    input  logic                           flush_i,
    output logic                           queue_empty_o,
    output logic                           busy_o
);

    VPU_uOP_t           head;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic [NUM_VREG-1:0] sb;
    logic [NUM_VREG-1:0] sb_next;
    logic [PORT_W-1:0]  head_port;
    logic               port_ready;
    logic               hazard;
    logic               issue;
    logic               push;
    logic               vcfg_issue;
    logic               is_vcfg;

    vpu_issue_queue #(.DEPTH(DEPTH)) u_queue (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push),
        .push_data (decode_entry_i),
        .pop       (issue),
        .flush     (flush_i),
        .head      (head),
        .count     (count),
        .full      (full)
    );

    // Head hazard against the registered scoreboard and ready of the head's port.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        head_port  = fu2port(head.fu);
        port_ready = 1'b0;
        for (int p = 0; p < NUM_FU; p++) begin
            if (head_port == PORT_W'(p)) port_ready = dispatch_ready_i[p];
        end
        hazard = (head.use_vs1    && sb[head.vs1]) ||
                 (head.use_vs2    && sb[head.vs2]) ||
                 (head.use_vd_src && sb[head.vd])  ||
                 (head.wr_vd      && sb[head.vd]);
    end

    // Issue, accept and VCFG decisions; all are gated off while in reset.
    always_comb begin
        is_vcfg    = (decode_entry_i.fu == FU_VCFG);
        issue      = rst_i && (count != '0) && !hazard && port_ready && !flush_i;
        push       = rst_i && decode_entry_valid_i && !is_vcfg && !full && !flush_i;
        vcfg_issue = rst_i && decode_entry_valid_i && is_vcfg && (count == '0) &&
                     (sb == '0) && !flush_i;
        dispatch_valid_o = '0;
        for (int p = 0; p < NUM_FU; p++) begin
            if (issue && head_port == PORT_W'(p)) dispatch_valid_o[p] = 1'b1;
        end
        decode_ack_o     = push || vcfg_issue;
        VCFG_valid_o     = vcfg_issue;
        VCFG_entry_o     = vcfg_issue ? decode_entry_i : '0;
        dispatch_entry_o = rst_i ? head : '0;
        queue_empty_o    = (count == '0);
        busy_o           = (count != '0) || (sb != '0);
    end

    // Scoreboard update: writebacks release, an issuing writer claims; claim wins on collision.
    always_comb begin
        sb_next = sb;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid_i[k]) sb_next[wb_vd_i[k]] = 1'b0;
        end
        if (issue && head.wr_vd) sb_next[head.vd] = 1'b1;
    end

    // Scoreboard register; flush leaves it alone since in-flight ops still write back.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) sb <= '0;
        else        sb <= sb_next;
    end

endmodule
